// File: rtl/elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl
//
// Elevator car controller that serves a bitmap of floor requests in SCAN
// order: the car keeps travelling in its preferred direction while requests
// remain ahead of it, then reverses. It tracks the current floor, times the
// travel between adjacent floors and the door-open interval, and emits a
// one-cycle arrival pulse at every stop.
//
// Parameters:
//   FLOORS      number of floors (>= 2), floors are 0..FLOORS-1
//   FLOOR_W     width of floor indices, 2**FLOOR_W >= FLOORS
//   TRAVEL_CYC  cycles spent moving between adjacent floors (>= 1)
//   DOOR_CYC    cycles the door stays open per stop (>= 1)
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   request strobe, one request per cycle
//   req_floor  in   requested floor (ignored when >= FLOORS)
//   floor      out  current car floor
//   dir_up     out  car is moving upward
//   dir_down   out  car is moving downward
//   door_open  out  door is open
//   arrive     out  one-cycle pulse on the first cycle of each stop
//   pending    out  registered bitmap of unserved requests
// ---------------------------------------------------------------------------
module elevator_scan_ctrl #(
    parameter int unsigned FLOORS     = 8,
    parameter int unsigned FLOOR_W    = 3,
    parameter int unsigned TRAVEL_CYC = 4,
    parameter int unsigned DOOR_CYC   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir_up,
    output logic               dir_down,
    output logic               door_open,
    output logic               arrive,
    output logic [FLOORS-1:0]  pending
);

    // One counter width serves both the travel and the door timer.
    localparam int unsigned CNT_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_e;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [FLOOR_W-1:0] floor_q,      floor_d;
    logic [FLOORS-1:0]  pending_q,    pending_d;
    logic               pref_up_q,    pref_up_d;
    logic [CNT_W-1:0]   travel_cnt_q, travel_cnt_d;
    logic [CNT_W-1:0]   door_cnt_q,   door_cnt_d;
    logic               arrive_q,     arrive_d;

    // -----------------------------------------------------------------------
    // Decoded helpers
    // -----------------------------------------------------------------------
    logic [FLOORS-1:0]  req_onehot;
    logic [FLOORS-1:0]  here_onehot;
    logic [FLOORS-1:0]  next_onehot;
    logic [FLOORS-1:0]  clear_mask;
    logic [FLOOR_W-1:0] next_floor;
    logic               above;
    logic               below;
    logic               here_pending;
    logic               next_pending;
    logic               absorb;

    // Floor one step in the preferred direction, clamped to the shaft ends.
    always_comb begin : next_floor_calc
        next_floor = floor_q;
        if (pref_up_q) begin
            if (floor_q != TOP_FLOOR) begin
                next_floor = floor_q + FLOOR_W'(1);
            end
        end else begin
            if (floor_q != '0) begin
                next_floor = floor_q - FLOOR_W'(1);
            end
        end
    end

    // Index decoding is done by comparing against every legal floor number,
    // so an out-of-range request floor simply produces an empty one-hot and
    // bitmap indices never exceed FLOORS-1.
    always_comb begin : decode
        req_onehot  = '0;
        here_onehot = '0;
        next_onehot = '0;
        above       = 1'b0;
        below       = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (req_floor == FLOOR_W'(i)) begin
                req_onehot[i] = 1'b1;
            end
            if (floor_q == FLOOR_W'(i)) begin
                here_onehot[i] = 1'b1;
            end
            if (next_floor == FLOOR_W'(i)) begin
                next_onehot[i] = 1'b1;
            end
            if (pending_q[i] && (FLOOR_W'(i) > floor_q)) begin
                above = 1'b1;
            end
            if (pending_q[i] && (FLOOR_W'(i) < floor_q)) begin
                below = 1'b1;
            end
        end
        here_pending = |(pending_q & here_onehot);
        next_pending = |(pending_q & next_onehot);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin : fsm_next
        state_d      = state_q;
        floor_d      = floor_q;
        pref_up_d    = pref_up_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        arrive_d     = 1'b0;
        clear_mask   = '0;
        absorb       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Only the registered bitmap drives the decision; a request
                // arriving this cycle is considered on the next one.
                if (|pending_q) begin
                    if (here_pending) begin
                        state_d    = S_DOOR;
                        door_cnt_d = '0;
                        clear_mask = here_onehot;
                        arrive_d   = 1'b1;
                    end else begin
                        state_d      = S_MOVE;
                        travel_cnt_d = '0;
                        pref_up_d    = above && (pref_up_q || !below);
                    end
                end
            end

            S_MOVE: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    floor_d      = next_floor;
                    travel_cnt_d = '0;
                    if (next_pending) begin
                        state_d    = S_DOOR;
                        door_cnt_d = '0;
                        clear_mask = next_onehot;
                        arrive_d   = 1'b1;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + CNT_W'(1);
                end
            end

            S_DOOR: begin
                // A call for the floor the car is standing at keeps the door
                // open for a fresh full interval instead of queueing a stop.
                absorb = req_valid && (req_floor == floor_q);
                if (absorb) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = S_IDLE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Service clears win over a same-cycle request for the same floor.
        pending_d = pending_q;
        if (req_valid && !absorb) begin
            pending_d = pending_d | req_onehot;
        end
        pending_d = pending_d & ~clear_mask;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin : regs
        if (reset) begin
            state_q      <= S_IDLE;
            floor_q      <= '0;
            pending_q    <= '0;
            pref_up_q    <= 1'b1;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
            arrive_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            pending_q    <= pending_d;
            pref_up_q    <= pref_up_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
            arrive_q     <= arrive_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registers only
    // -----------------------------------------------------------------------
    assign floor     = floor_q;
    assign pending   = pending_q;
    assign dir_up    = (state_q == S_MOVE) &&  pref_up_q;
    assign dir_down  = (state_q == S_MOVE) && !pref_up_q;
    assign door_open = (state_q == S_DOOR);
    assign arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_scan_ctrl
//
// Two instances: A with default parameters, B with FLOORS=6, TRAVEL_CYC=1,
// DOOR_CYC=2. A behavioural model (phase + countdown timers per car) is
// checked against both every cycle, directed scenarios pin the model with
// hand-computed literals, and a random phase exercises the rest.
// ---------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic       a_req_valid;
    logic [2:0] a_req_floor;
    logic [2:0] a_floor;
    logic       a_dir_up, a_dir_down, a_door_open, a_arrive;
    logic [7:0] a_pending;

    logic       b_req_valid;
    logic [2:0] b_req_floor;
    logic [2:0] b_floor;
    logic       b_dir_up, b_dir_down, b_door_open, b_arrive;
    logic [5:0] b_pending;

    elevator_scan_ctrl #(
        .FLOORS    (8),
        .FLOOR_W   (3),
        .TRAVEL_CYC(4),
        .DOOR_CYC  (6)
    ) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .req_valid(a_req_valid),
        .req_floor(a_req_floor),
        .floor    (a_floor),
        .dir_up   (a_dir_up),
        .dir_down (a_dir_down),
        .door_open(a_door_open),
        .arrive   (a_arrive),
        .pending  (a_pending)
    );

    elevator_scan_ctrl #(
        .FLOORS    (6),
        .FLOOR_W   (3),
        .TRAVEL_CYC(1),
        .DOOR_CYC  (2)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .req_valid(b_req_valid),
        .req_floor(b_req_floor),
        .floor    (b_floor),
        .dir_up   (b_dir_up),
        .dir_down (b_dir_down),
        .door_open(b_door_open),
        .arrive   (b_arrive),
        .pending  (b_pending)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    bit done    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Behavioural model. phase: 0 parked, 1 travelling, 2 door open.
    // tleft counts down the cycles left in the current hop, dleft the
    // cycles left with the door open.
    // -----------------------------------------------------------------------
    int       P_FL[2] = '{8, 6};
    int       P_TR[2] = '{4, 1};
    int       P_DR[2] = '{6, 2};

    int       m_phase[2];
    int       m_pos[2];
    int       m_tleft[2];
    int       m_dleft[2];
    bit [7:0] m_pend[2];
    bit       m_up[2];
    bit       m_arr[2];

    function automatic bit has(input bit [7:0] p, input int f);
        return ((p >> f) & 8'd1) != 8'd0;
    endfunction

    task automatic model_reset(input int id);
        m_phase[id] = 0;
        m_pos[id]   = 0;
        m_tleft[id] = 0;
        m_dleft[id] = 0;
        m_pend[id]  = '0;
        m_up[id]    = 1'b1;
        m_arr[id]   = 1'b0;
    endtask

    task automatic model_step(input int id, input bit rst, input bit v, input int rf);
        int       served;
        int       np;
        bit       absorbed;
        bit       above;
        bit       below;
        bit [7:0] p;
        if (rst) begin
            model_reset(id);
            return;
        end
        served    = -1;
        absorbed  = 1'b0;
        p         = m_pend[id];
        m_arr[id] = 1'b0;
        case (m_phase[id])
            0: begin
                if (p != 8'd0) begin
                    if (has(p, m_pos[id])) begin
                        m_phase[id] = 2;
                        m_dleft[id] = P_DR[id];
                        served      = m_pos[id];
                        m_arr[id]   = 1'b1;
                    end else begin
                        above = 1'b0;
                        below = 1'b0;
                        for (int f = 0; f < P_FL[id]; f++) begin
                            if (has(p, f) && f > m_pos[id]) above = 1'b1;
                            if (has(p, f) && f < m_pos[id]) below = 1'b1;
                        end
                        m_up[id]    = above && (m_up[id] || !below);
                        m_phase[id] = 1;
                        m_tleft[id] = P_TR[id];
                    end
                end
            end
            1: begin
                m_tleft[id] = m_tleft[id] - 1;
                if (m_tleft[id] == 0) begin
                    np          = m_up[id] ? m_pos[id] + 1 : m_pos[id] - 1;
                    m_pos[id]   = np;
                    m_tleft[id] = P_TR[id];
                    if (has(p, np)) begin
                        m_phase[id] = 2;
                        m_dleft[id] = P_DR[id];
                        served      = np;
                        m_arr[id]   = 1'b1;
                    end
                end
            end
            default: begin
                if (v && rf == m_pos[id]) begin
                    m_dleft[id] = P_DR[id];
                    absorbed    = 1'b1;
                end else begin
                    m_dleft[id] = m_dleft[id] - 1;
                    if (m_dleft[id] == 0) m_phase[id] = 0;
                end
            end
        endcase
        if (v && rf < P_FL[id] && !absorbed && rf != served) p = p | (8'd1 << rf);
        if (served >= 0) p = p & ~(8'd1 << served);
        m_pend[id] = p;
    endtask

    initial begin : model_proc
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            model_step(0, reset, a_req_valid, int'(a_req_floor));
            model_step(1, reset, b_req_valid, int'(b_req_floor));
        end
    end

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    task automatic cmp_inst(input int id, input int fl, input bit du, input bit dd,
                            input bit dopen, input bit arr, input int pend);
        int ef;
        int ep;
        bit eu;
        bit ed;
        bit eo;
        bit ea;
        ef = m_pos[id];
        eu = (m_phase[id] == 1) &&  m_up[id];
        ed = (m_phase[id] == 1) && !m_up[id];
        eo = (m_phase[id] == 2);
        ea = m_arr[id];
        ep = int'(m_pend[id]);
        n_tests++;
        if (fl != ef || du != eu || dd != ed || dopen != eo || arr != ea || pend != ep) begin
            n_fail++;
            $display("FAIL model_%0d cyc=%0d got floor=%0d up=%0b down=%0b door=%0b arrive=%0b pending=%0h expected floor=%0d up=%0b down=%0b door=%0b arrive=%0b pending=%0h",
                     id, cyc, fl, du, dd, dopen, arr, pend, ef, eu, ed, eo, ea, ep);
        end
        n_tests++;
        if (int'(du) + int'(dd) + int'(dopen) > 1) begin
            n_fail++;
            $display("FAIL excl_%0d cyc=%0d got up=%0b down=%0b door=%0b expected at most one set",
                     id, cyc, du, dd, dopen);
        end
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (chk_en && !done) begin
                cmp_inst(0, int'(a_floor), a_dir_up, a_dir_down, a_door_open, a_arrive, int'(a_pending));
                cmp_inst(1, int'(b_floor), b_dir_up, b_dir_down, b_door_open, b_arrive, int'(b_pending));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_a(input int f, output int c);
        @(posedge clk);
        #1;
        a_req_valid = 1'b1;
        a_req_floor = f[2:0];
        c = cyc;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
    endtask

    task automatic pulse_b(input int f, output int c);
        @(posedge clk);
        #1;
        b_req_valid = 1'b1;
        b_req_floor = f[2:0];
        c = cyc;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        if (!done) begin
            n_fail++;
            $display("FAIL watchdog cyc=%0d got no completion expected end of stimulus", cyc);
            done = 1'b1;
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin : main
        int c0, c1, c2, c3, c4, c5, d, t, r;
        reset       = 1'b1;
        a_req_valid = 1'b0;
        a_req_floor = '0;
        b_req_valid = 1'b0;
        b_req_floor = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_floor", int'(a_floor), 0);
        chk("rst_pending", int'(a_pending), 0);
        chk("rst_outs", int'({a_dir_up, a_dir_down, a_door_open, a_arrive}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single trip 0 -> 3 with default timing.
        pulse_a(3, c0);
        at_cycle(c0 + 1);  chk("s1_pend", int'(a_pending), 8);
                           chk("s1_idle_up", int'(a_dir_up), 0);
        at_cycle(c0 + 2);  chk("s1_up2", int'(a_dir_up), 1);
        at_cycle(c0 + 6);  chk("s1_floor1", int'(a_floor), 1);
        at_cycle(c0 + 10); chk("s1_floor2", int'(a_floor), 2);
        at_cycle(c0 + 13); chk("s1_up13", int'(a_dir_up), 1);
                           chk("s1_floor13", int'(a_floor), 2);
        at_cycle(c0 + 14); chk("s1_floor3", int'(a_floor), 3);
                           chk("s1_arrive", int'(a_arrive), 1);
                           chk("s1_door14", int'(a_door_open), 1);
                           chk("s1_up14", int'(a_dir_up), 0);
                           chk("s1_pend14", int'(a_pending), 0);
        at_cycle(c0 + 15); chk("s1_arrive15", int'(a_arrive), 0);
        at_cycle(c0 + 19); chk("s1_door19", int'(a_door_open), 1);
        at_cycle(c0 + 20); chk("s1_door20", int'(a_door_open), 0);

        // Request for the floor the parked car is at.
        pulse_a(3, c1);
        at_cycle(c1 + 1);  chk("s2_pend", int'(a_pending), 8);
        at_cycle(c1 + 2);  chk("s2_door", int'(a_door_open), 1);
                           chk("s2_arrive", int'(a_arrive), 1);
                           chk("s2_pend2", int'(a_pending), 0);
        at_cycle(c1 + 7);  chk("s2_door7", int'(a_door_open), 1);
        at_cycle(c1 + 8);  chk("s2_door8", int'(a_door_open), 0);

        // SCAN ordering: up to 6, pick up 5 on the way, then back down to 1.
        pulse_a(6, c2);
        at_cycle(c2 + 2);
        pulse_a(1, t);
        pulse_a(5, t);
        at_cycle(c2 + 10); chk("s3_floor5", int'(a_floor), 5);
                           chk("s3_arr5", int'(a_arrive), 1);
        at_cycle(c2 + 16); chk("s3_idle16", int'({a_dir_up, a_door_open}), 0);
        at_cycle(c2 + 17); chk("s3_up17", int'(a_dir_up), 1);
        at_cycle(c2 + 20); chk("s3_down20", int'(a_dir_down), 0);
        at_cycle(c2 + 21); chk("s3_floor6", int'(a_floor), 6);
                           chk("s3_arr6", int'(a_arrive), 1);
        at_cycle(c2 + 27); chk("s3_idle27", int'({a_dir_down, a_door_open}), 0);
        at_cycle(c2 + 28); chk("s3_down28", int'(a_dir_down), 1);
                           chk("s3_pend28", int'(a_pending), 2);
        at_cycle(c2 + 48); chk("s3_floor1", int'(a_floor), 1);
                           chk("s3_arr1", int'(a_arrive), 1);

        // Door restart by a call for the current floor.
        at_cycle(c2 + 56);
        pulse_a(2, c3);
        at_cycle(c3 + 6);  chk("s4_floor2", int'(a_floor), 2);
                           chk("s4_arr", int'(a_arrive), 1);
        at_cycle(c3 + 8);
        pulse_a(2, r);
        at_cycle(r + 1);   chk("s4_noarr", int'(a_arrive), 0);
                           chk("s4_nopend", int'(a_pending), 0);
                           chk("s4_door1", int'(a_door_open), 1);
        at_cycle(r + 6);   chk("s4_door6", int'(a_door_open), 1);
        at_cycle(r + 7);   chk("s4_door7", int'(a_door_open), 0);

        // Reset while travelling between floors 2 and 3 with {3,6} pending.
        at_cycle(r + 8);
        pulse_a(6, c4);
        pulse_a(3, t);
        @(posedge clk);
        #1;
        chk("s5_pend", int'(a_pending), 8'h48);
        chk("s5_up", int'(a_dir_up), 1);
        chk("s5_floor", int'(a_floor), 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("s5_rfloor", int'(a_floor), 0);
        chk("s5_rpend", int'(a_pending), 0);
        chk("s5_routs", int'({a_dir_up, a_dir_down, a_door_open, a_arrive}), 0);
        at_cycle(c4 + 12);
        chk("s5_late", int'({a_dir_up, a_dir_down, a_door_open, a_arrive}), 0);
        chk("s5_late_floor", int'(a_floor), 0);

        // Six-floor instance: out-of-range request, then a repeated request.
        pulse_b(7, c5);
        at_cycle(c5 + 1);  chk("b_oor_pend", int'(b_pending), 0);
        at_cycle(c5 + 2);  chk("b_oor_idle", int'({b_dir_up, b_dir_down, b_door_open}), 0);
        pulse_b(5, d);
        pulse_b(5, t);
        at_cycle(d + 1);   chk("b_pend", int'(b_pending), 32);
        at_cycle(d + 7);   chk("b_floor5", int'(b_floor), 5);
                           chk("b_arr", int'(b_arrive), 1);
                           chk("b_door", int'(b_door_open), 1);
        at_cycle(d + 8);   chk("b_pend8", int'(b_pending), 0);
                           chk("b_arr8", int'(b_arrive), 0);
        at_cycle(d + 9);   chk("b_door9", int'(b_door_open), 0);
        at_cycle(d + 11);  chk("b_idle", int'({b_dir_up, b_dir_down, b_door_open}), 0);
                           chk("b_stay5", int'(b_floor), 5);

        // Random traffic on both cars, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            a_req_valid = ($urandom_range(0, 3) == 0);
            a_req_floor = 3'($urandom_range(0, 7));
            b_req_valid = ($urandom_range(0, 3) == 0);
            b_req_floor = 3'($urandom_range(0, 7));
            reset       = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        reset       = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised successor of the single destination/floor compare.
- Holds a bitmap of pending floor requests and tracks the car's current floor.
- Serves requests in SCAN order (keep going in one direction while requests remain ahead, then reverse).
- Drives direction, travel timing, door timing and arrival pulses for the display and motor blocks.

Parameters:
- FLOORS, 8, number of floors (>=2); floors are 0..FLOORS-1.
- FLOOR_W, 3, width of floor indices; must satisfy 2**FLOOR_W >= FLOORS.
- TRAVEL_CYC, 4, clock cycles spent moving between adjacent floors (>=1).
- DOOR_CYC, 6, clock cycles the door stays open per stop (>=1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe; one request captured per cycle.
- req_floor  in  FLOOR_W  floor requested when req_valid=1.
- floor  out  FLOOR_W  current car floor.
- dir_up  out  1  car is moving upward.
- dir_down  out  1  car is moving downward.
- door_open  out  1  door is open.
- arrive  out  1  one-cycle pulse on the first cycle of each stop.
- pending  out  FLOORS  registered bitmap of unserved requests.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=IDLE; floor=0; pending=0; pref=UP; both counters 0.
  - All 1-bit outputs 0.
  - Reset applied mid-move or with the door open abandons that operation immediately; no pending bit survives.
- Request capture:
  - When req_valid=1 and req_floor<FLOORS, the bit is set at the clock edge and is visible in pending the next cycle.
  - req_floor>=FLOORS is ignored.
  - A duplicate request for an already-pending floor has no effect.
- Absorbed requests (no pending bit is set):
  - req_floor==floor while state=DOOR: the door counter restarts and the door stays open a full DOOR_CYC from the next cycle.
  - req_floor matches the floor being cleared in the same cycle: the request is absorbed.
- State IDLE: decision is based on the registered pending only.
  - pending==0: stay IDLE.
  - pending[floor]=1: go to DOOR; clear the bit; arrive=1 on the first DOOR cycle.
  - Requests above and (pref=UP or none below): go to MOVE with pref=UP.
  - Otherwise: go to MOVE with pref=DOWN.
- State MOVE:
  - dir_up=(pref==UP) and dir_down=(pref==DOWN), both registered with the state.
  - The travel counter counts TRAVEL_CYC cycles. At the edge ending the last one, floor steps by ±1 and the counter reloads.
  - If the new floor is pending: same edge enters DOOR, clears the bit, and pulses arrive. Direction outputs drop that cycle.
  - If the new floor is not pending: remain in MOVE in the same direction.
  - floor never leaves 0..FLOORS-1. A target always exists ahead because bits clear only on service.
- State DOOR:
  - door_open=1 for DOOR_CYC cycles (longer if restarted by an absorbed request), then IDLE for at least one cycle.
  - pref is retained, so IDLE continues in the same direction if requests lie ahead, else reverses.
- Exclusivity: dir_up, dir_down and door_open are mutually exclusive in every cycle.
- Latency from IDLE (cycle 0 = req_valid cycle):
  - Pending bit visible at cycle 1; MOVE begins at cycle 2.
  - Arrival k floors away occurs at cycle 2+k*TRAVEL_CYC.
- Arithmetic:
  - Above/below tests are comparisons of bitmap indices against floor, computed over the FLOORS range only.
  - Counters are sized for max(TRAVEL_CYC, DOOR_CYC).

Test Plan:
- Reset, then req 3 at cycle 0 (defaults) -> dir_up cycles 2-13; floor=1@6, 2@10, 3@14; arrive and door_open @14; door_open through 19; IDLE @20; pending=0 from 14.
- At floor 3 with door closed, req 3 -> pending[3]=1 @1, door_open+arrive @2 for 6 cycles, pending[3]=0 @2.
- At floor 3 moving up toward pending 6, req 1 and req 5 -> stops at 5, then 6, then reverses to 1; arrive pulses in order 5, 6, 1; dir_down asserted only after the 6 stop.
- Door open at floor 2 (4 cycles in), req 2 -> door_open extends to 6 cycles after the request; no pending bit set; no extra arrive.
- FLOORS=6, FLOOR_W=3: req_floor=7 -> pending unchanged, state stays IDLE; req 5 then req 5 repeated -> single stop at 5.
- Reset asserted mid-move between floors 2 and 3 with pending={3,6} -> next cycle floor=0, pending=0, all outputs 0; no arrive pulse afterwards.
